// File: rtl/btn_pkg.sv
// Shared timing defaults and counter-width helpers for the push-button bank.
package btn_pkg;

  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20000;
  localparam int unsigned DEF_LONG_CYCLES     = 20000000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;

  // Debounce counter holds 0..DEBOUNCE_CYCLES.
  function automatic int unsigned dcnt_w(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Hold counter saturates at LONG_CYCLES.
  function automatic int unsigned hcnt_w(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Repeat counter only spans 0..REPEAT_CYCLES-1.
  function automatic int unsigned rcnt_w(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce, press/release edges, long-press and auto-repeat.
module button_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DCNT_W = dcnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned HCNT_W = hcnt_w(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DCNT_W-1:0]      dcnt;
  logic [HCNT_W-1:0]      hcnt;
  logic                   s;
  logic                   accept;
  logic                   rel_accept;
  logic                   hold_run;
  logic                   hold_full;

  assign s          = sync_q[SYNC_STAGES-1];
  assign accept     = (s != level) && (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1));
  assign rel_accept = accept && !s;
  // A release accepted this cycle kills any long/repeat pulse due on the same edge.
  assign hold_run   = level && !rel_accept;
  assign hold_full  = (hcnt == HCNT_W'(LONG_CYCLES));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Debounce and edge pulses; pulses register alongside the level update.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dcnt          <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= accept && s;
      release_pulse <= rel_accept;
      if (s == level) begin
        dcnt <= '0;
      end else if (accept) begin
        level <= s;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= hold_run && (hcnt == HCNT_W'(LONG_CYCLES - 1));
      if (!hold_run)      hcnt <= '0;
      else if (!hold_full) hcnt <= hcnt + HCNT_W'(1);
    end
  end

  if (REPEAT_CYCLES == 0) begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end else begin : g_repeat
    localparam int unsigned RCNT_W = rcnt_w(REPEAT_CYCLES);
    logic [RCNT_W-1:0] rcnt;
    logic              rep_run;

    assign rep_run = hold_run && hold_full;

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        rcnt         <= '0;
        repeat_pulse <= 1'b0;
      end else if (!rep_run) begin
        rcnt         <= '0;
        repeat_pulse <= 1'b0;
      end else if (rcnt == RCNT_W'(REPEAT_CYCLES - 1)) begin
        rcnt         <= '0;
        repeat_pulse <= 1'b1;
      end else begin
        rcnt         <= rcnt + RCNT_W'(1);
        repeat_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/button_bank_handler.sv
// Bank of independent debounced push-button channels with a shared any-press flag.
module button_bank_handler
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_BTN-1:0] raw_button,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic               any_press
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .raw           (raw_button[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_button_bank_handler.sv
// Directed bench for button_bank_handler with short timing parameters.
module tb_button_bank_handler;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [1:0] raw_button;
  logic [1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic       any_press;

  int total = 0;
  int passed = 0;
  int n_press, n_rel, n_long, n_rep;
  logic [1:0] lvl_seen;

  button_bank_handler #(
    .NUM_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .raw_button    (raw_button),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] all_outs();
    return {5'd0, level, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press};
  endfunction

  // Advance one edge, sample 1 time unit later and tally channel-0 pulses.
  task automatic step();
    @(posedge CLK);
    #1;
    n_press += int'(press_pulse[0]);
    n_rel   += int'(release_pulse[0]);
    n_long  += int'(long_pulse[0]);
    n_rep   += int'(repeat_pulse[0]);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0;
  endtask

  task automatic chk_counts(input string tag, input int p, input int r, input int l, input int rp);
    chk({tag, "_press_cnt"},   16'(n_press), 16'(p));
    chk({tag, "_release_cnt"}, 16'(n_rel),   16'(r));
    chk({tag, "_long_cnt"},    16'(n_long),  16'(l));
    chk({tag, "_repeat_cnt"},  16'(n_rep),   16'(rp));
  endtask

  initial begin
    RESET_N    = 1'b0;
    raw_button = 2'b00;
    clear_counts();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", all_outs(), 16'd0);
    RESET_N = 1'b1;
    step();
    step();

    // Clean press on channel 0, short hold, release
    clear_counts();
    raw_button = 2'b01;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 5) chk("a_level_pre", 16'(level), 16'h0);
      if (e == 6) begin
        chk("a_level", 16'(level), 16'h1);
        chk("a_press", 16'(press_pulse), 16'h1);
        chk("a_any", 16'(any_press), 16'h1);
      end
      if (e == 7) begin
        chk("a_press_clear", 16'(press_pulse), 16'h0);
        chk("a_any_clear", 16'(any_press), 16'h0);
        raw_button = 2'b00;
      end
      if (e == 13) begin
        chk("a_level_fall", 16'(level), 16'h0);
        chk("a_release", 16'(release_pulse), 16'h1);
      end
      if (e == 14) chk("a_release_clear", 16'(release_pulse), 16'h0);
    end
    chk_counts("a", 1, 1, 0, 0);

    // Bounce shorter than the debounce window
    clear_counts();
    lvl_seen = 2'b00;
    for (int e = 0; e < 20; e++) begin
      raw_button = (e < 8 && ((e / 2) % 2 == 0)) ? 2'b01 : 2'b00;
      step();
      lvl_seen |= level;
    end
    chk("b_level_never", 16'(lvl_seen), 16'h0);
    chk_counts("b", 0, 0, 0, 0);

    // Release accepted exactly on the long threshold edge
    clear_counts();
    raw_button = 2'b01;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (e == 6) chk("c_press", 16'(press_pulse), 16'h1);
      if (e == 10) raw_button = 2'b00;
      if (e == 16) begin
        chk("c_level_fall", 16'(level), 16'h0);
        chk("c_release", 16'(release_pulse), 16'h1);
        chk("c_long_suppressed", 16'(long_pulse), 16'h0);
      end
    end
    chk_counts("c", 1, 1, 0, 0);

    // Long press with auto-repeat, then release
    clear_counts();
    raw_button = 2'b01;
    for (int e = 1; e <= 45; e++) begin
      step();
      if (e == 15) chk("d_long_early", 16'(long_pulse), 16'h0);
      if (e == 16) begin
        chk("d_long", 16'(long_pulse), 16'h1);
        chk("d_no_rep_with_long", 16'(repeat_pulse), 16'h0);
      end
      if (e == 17) chk("d_long_once", 16'(long_pulse), 16'h0);
      if (e == 18) chk("d_rep_early", 16'(repeat_pulse), 16'h0);
      if (e == 19) chk("d_rep1", 16'(repeat_pulse), 16'h1);
      if (e == 20) begin
        chk("d_rep1_clear", 16'(repeat_pulse), 16'h0);
        chk("d_ch1_idle", 16'(level[1]), 16'h0);
      end
      if (e == 22) chk("d_rep2", 16'(repeat_pulse), 16'h1);
      if (e == 30) raw_button = 2'b00;
      if (e == 36) begin
        chk("d_release", 16'(release_pulse), 16'h1);
        chk("d_level_fall", 16'(level), 16'h0);
      end
    end
    chk_counts("d", 1, 1, 1, 6);

    // Simultaneous press on both channels
    raw_button = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 6) begin
        chk("e_press_both", 16'(press_pulse), 16'h3);
        chk("e_any", 16'(any_press), 16'h1);
      end
      if (e == 7) begin
        chk("e_press_clear", 16'(press_pulse), 16'h0);
        chk("e_any_clear", 16'(any_press), 16'h0);
      end
    end

    // Asynchronous reset mid-hold, button still held afterwards
    #2;
    RESET_N = 1'b0;
    #1;
    chk("f_reset_async", all_outs(), 16'd0);
    step();
    step();
    chk("f_reset_held", all_outs(), 16'd0);
    RESET_N = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 5) begin
        chk("f_level_pre", 16'(level), 16'h0);
        chk("f_press_pre", 16'(press_pulse), 16'h0);
      end
      if (e == 6) begin
        chk("f_press_again", 16'(press_pulse), 16'h3);
        chk("f_level_again", 16'(level), 16'h3);
        chk("f_any_again", 16'(any_press), 16'h1);
      end
    end
    raw_button = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
